// File: rtl/display_scan_if.sv
// Handshake/bus bundle for the 4-digit multiplexed 7-segment scan controller.
// The master drives the controls and segment patterns; the slave (controller) drives the display.
interface display_scan_if;
  logic       enable;
  logic       load;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [3:0] d1;
  logic [6:0] d7;
  logic [1:0] scan_index;
  logic       pending;
  logic       frame_done;

  modport master (
    output enable, load, seg0, seg1, seg2, seg3,
    input  d1, d7, scan_index, pending, frame_done
  );

  modport slave (
    input  enable, load, seg0, seg1, seg2, seg3,
    output d1, d7, scan_index, pending, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Glitch-free 4-digit 7-segment scanner with per-slot blanking and a
// double-buffered pattern bank that only commits at frame boundaries.

module display_digit_bank #(
  parameter int unsigned SEG_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             commit,
  input  logic             pending,
  input  logic [SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0] active_q
);
  logic [SEG_W-1:0] shadow_q, shadow_d, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (load) shadow_d = seg_in;
    // a load landing on the commit edge bypasses the shadow straight into active
    if (commit) begin
      if (load)         active_d = seg_in;
      else if (pending) active_d = shadow_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= '1;
      active_q <= '1;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
endmodule

module display_scan_controller #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 20
) (
  input  logic          clock,
  input  logic          reset,
  display_scan_if.slave bus
);
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_e;

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [1:0]                          idx_q, idx_d;
  logic [NUM_DIGITS-1:0]               d1_q, d1_d;
  logic [SEG_W-1:0]                    d7_q, d7_d;
  logic                                pending_q, pending_d;
  logic                                frame_done_q, frame_done_d;
  logic                                slot_end, commit;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    seg_in, active_q;

  assign seg_in   = {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  assign slot_end = (state_q == ST_SHOW) && (cnt_q == CNT_W'(TICK_DIV - 1));
  assign commit   = slot_end && (idx_q == 2'd3);

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_bank
      display_digit_bank #(.SEG_W(SEG_W)) u_bank (
        .clock    (clock),
        .reset    (reset),
        .load     (bus.load),
        .commit   (commit),
        .pending  (pending_q),
        .seg_in   (seg_in[g]),
        .active_q (active_q[g])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    frame_done_d = commit;
    d1_d         = '1;
    d7_d         = '1;

    unique case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.enable) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (slot_end) begin
          cnt_d = '0;
          if (!bus.enable) begin
            state_d = ST_OFF;
            idx_d   = '0;
          end else begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (commit)        pending_d = 1'b0;
    else if (bus.load) pending_d = 1'b1;

    // SHOW is never entered on a commit edge, so the current active bank is the one to show
    if (state_d == ST_SHOW) begin
      d1_d = ~(NUM_DIGITS'(1) << idx_d);
      d7_d = active_q[idx_d];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      d1_q         <= '1;
      d7_q         <= '1;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      d1_q         <= d1_d;
      d7_q         <= d7_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.d1         = d1_q;
  assign bus.d7         = d7_q;
  assign bus.scan_index = idx_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
endmodule
